rom_port_arbiter: RTL

//  Shares the single-port, 1-cycle-latency instruction ROM between instruction fetch (IF) and

---
 rtl/rom_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Shares the single-port, 1-cycle-latency ROM between instruction fetch and data loads.
// Optional build macro ROM_ARB_PERF_EN adds 32-bit grant/conflict performance counters.
module rom_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
`ifdef ROM_ARB_PERF_EN
  output logic [31:0]       perf_if_gnt,
  output logic [31:0]       perf_dm_gnt,
  output logic [31:0]       perf_conflict,
`endif
  output logic              rom_en,
  output logic [3:0]        rom_write_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_read_data
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_IF    = 2'd1,
    TAG_DM    = 2'd2,
    TAG_DMERR = 2'd3
  } tag_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  tag_e              tag_q, tag_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              dm_misaligned;
  logic              unused_if_low;

  assign rom_write_en  = 4'b0000;
  assign dm_misaligned = (dm_addr[1:0] != 2'b00);
  // Instruction fetches always return the aligned word, so the byte offset is dropped.
  assign unused_if_low = ^if_addr[1:0];

  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    rom_en   = 1'b0;
    rom_addr = '0;
    tag_d    = TAG_NONE;
    starve_d = starve_q;
    if (!rst) begin
      if_gnt = if_req && (!dm_req || (starve_q == STARVE_LIM));
      dm_gnt = dm_req && !if_gnt;
      if (if_gnt) begin
        rom_en   = 1'b1;
        rom_addr = {if_addr[ADDR_W-1:2], 2'b00};
        tag_d    = TAG_IF;
      end else if (dm_gnt) begin
        if (dm_misaligned) begin
          tag_d = TAG_DMERR;
        end else begin
          rom_en   = 1'b1;
          rom_addr = {dm_addr[ADDR_W-1:2], 2'b00};
          tag_d    = TAG_DM;
        end
      end
      if (if_gnt || !if_req) begin
        starve_d = 4'd0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Response side: the tag registered at grant steers the ROM data one cycle later.
  always_comb begin
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    dm_err    = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    if (!rst) begin
      if_rvalid = (tag_q == TAG_IF) && !if_flush;
      dm_rvalid = (tag_q == TAG_DM) || (tag_q == TAG_DMERR);
      dm_err    = (tag_q == TAG_DMERR);
      if_rdata  = if_rvalid ? rom_read_data : if_rdata_q;
      case (tag_q)
        TAG_DM:    dm_rdata = rom_read_data;
        TAG_DMERR: dm_rdata = '0;
        default:   dm_rdata = dm_rdata_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= TAG_NONE;
      starve_q   <= 4'd0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      tag_q      <= tag_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata;
      dm_rdata_q <= dm_rdata;
    end
  end

`ifdef ROM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_dm_q, perf_cf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
      perf_cf_q <= '0;
    end else begin
      perf_if_q <= perf_if_q + {31'd0, if_gnt};
      perf_dm_q <= perf_dm_q + {31'd0, dm_gnt};
      perf_cf_q <= perf_cf_q + {31'd0, (if_req && dm_req)};
    end
  end

  assign perf_if_gnt   = perf_if_q;
  assign perf_dm_gnt   = perf_dm_q;
  assign perf_conflict = perf_cf_q;
`endif

endmodule
